// File: rtl/alu_pkg.sv
// Shared opcode values, status-flag bit positions and multiplier FSM states
// for the sequential ALU.
package alu_pkg;

   // Opcodes carried on in_cmd; any value not listed decodes as unknown.
   localparam logic [3:0] OP_MOV = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_ADC = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_SBC = 4'b0101;
   localparam logic [3:0] OP_AND = 4'b0110;
   localparam logic [3:0] OP_ORR = 4'b0111;
   localparam logic [3:0] OP_EOR = 4'b1000;
   localparam logic [3:0] OP_MVN = 4'b1001;
   localparam logic [3:0] OP_MUL = 4'b1010;
   localparam logic [3:0] OP_CMP = 4'b1100;
   localparam logic [3:0] OP_TST = 4'b1101;

   // Bit positions inside the 4-bit status register {Z,C,N,V}.
   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

   // Multiplier sequencing: IDLE accepts commands, BUSY iterates, DONE retires.
   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// Only the low WIDTH bits of the product are kept.
module alu_seq_mul #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    count_q, count_d;
   logic             busy_q, busy_d;

   // done flags the cycle in which the last bit is consumed; product is
   // complete from the following cycle on.
   assign done    = busy_q && (count_q == CW'(WIDTH - 1));
   assign product = acc_q;

   // Load operands on start, otherwise add-and-shift while busy.
   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      count_d  = count_q;
      busy_d   = busy_q;
      if (start) begin
         mcand_d  = op_a;
         mplier_d = op_b;
         acc_d    = '0;
         count_d  = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         count_d  = count_q + 1'b1;
         if (count_q == CW'(WIDTH - 1)) begin
            busy_d = 1'b0;
         end
      end
   end

   // Multiplier state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and NZCV status register.
// Single-cycle ops complete in the accept edge; MUL runs through alu_seq_mul.
// MOV/MVN take their operand from in_val2.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_cmd,
   input  logic             in_s,
   input  logic [WIDTH-1:0] in_val1,
   input  logic [WIDTH-1:0] in_val2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_wb,
   output logic [3:0]       sr
);

   mul_state_e       state_q, state_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             wb_q, wb_d;
   logic             valid_q, valid_d;
   logic [3:0]       sr_q, sr_d;
   logic             mul_s_q, mul_s_d;
   logic             ready_en_q;

   logic             accept;
   logic             is_sub, carry_in, v_add, v_sub;
   logic [WIDTH-1:0] op2;
   logic [WIDTH:0]   sum;

   logic [WIDTH-1:0] dec_res;
   logic             dec_wb, dec_upd_nz, dec_upd_cv, dec_mul, dec_v;

   logic             mul_start, mul_done;
   logic [WIDTH-1:0] mul_product;

   // ready_en_q keeps in_ready low while reset is held and releases it one edge later.
   assign in_ready   = ready_en_q && (state_q == MUL_IDLE) && (!valid_q || out_ready);
   assign accept     = in_valid && in_ready;
   assign out_valid  = valid_q;
   assign out_result = res_q;
   assign out_wb     = wb_q;
   assign sr         = sr_q;

   // Shared WIDTH+1 bit adder; subtraction is a + ~b + carry (carry = NOT borrow).
   always_comb begin
      is_sub = (in_cmd == OP_SUB) || (in_cmd == OP_SBC) || (in_cmd == OP_CMP);
      op2    = is_sub ? ~in_val2 : in_val2;
      case (in_cmd)
         OP_ADC, OP_SBC: carry_in = sr_q[FLAG_C];
         OP_SUB, OP_CMP: carry_in = 1'b1;
         default:        carry_in = 1'b0;
      endcase
      sum   = {1'b0, in_val1} + {1'b0, op2} + {{WIDTH{1'b0}}, carry_in};
      v_add = (in_val1[WIDTH-1] ~^ in_val2[WIDTH-1]) & (sum[WIDTH-1] ^ in_val1[WIDTH-1]);
      v_sub = (in_val1[WIDTH-1] ^ in_val2[WIDTH-1]) & (sum[WIDTH-1] ^ in_val1[WIDTH-1]);
   end

   // Opcode decode: result value, writeback and which flags this op may touch.
   always_comb begin
      dec_res    = '0;
      dec_wb     = 1'b0;
      dec_upd_nz = 1'b0;
      dec_upd_cv = 1'b0;
      dec_mul    = 1'b0;
      dec_v      = is_sub ? v_sub : v_add;
      case (in_cmd)
         OP_MOV: begin dec_res = in_val2;           dec_wb = 1'b1; dec_upd_nz = in_s; end
         OP_MVN: begin dec_res = ~in_val2;          dec_wb = 1'b1; dec_upd_nz = in_s; end
         OP_AND: begin dec_res = in_val1 & in_val2; dec_wb = 1'b1; dec_upd_nz = in_s; end
         OP_ORR: begin dec_res = in_val1 | in_val2; dec_wb = 1'b1; dec_upd_nz = in_s; end
         OP_EOR: begin dec_res = in_val1 ^ in_val2; dec_wb = 1'b1; dec_upd_nz = in_s; end
         OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
            dec_res    = sum[WIDTH-1:0];
            dec_wb     = 1'b1;
            dec_upd_nz = in_s;
            dec_upd_cv = in_s;
         end
         OP_CMP: begin
            dec_res    = sum[WIDTH-1:0];
            dec_upd_nz = 1'b1;
            dec_upd_cv = 1'b1;
         end
         OP_TST: begin dec_res = in_val1 & in_val2; dec_upd_nz = 1'b1; end
         OP_MUL: begin
            // With the multiplier compiled out MUL falls through as unknown.
            if (MUL_EN) begin
               dec_mul = 1'b1;
            end
         end
         default: begin end
      endcase
   end

   // Output register, status register and MUL sequencing.
   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      wb_d      = wb_q;
      valid_d   = valid_q && !out_ready;
      sr_d      = sr_q;
      mul_s_d   = mul_s_q;
      mul_start = 1'b0;
      case (state_q)
         MUL_IDLE: begin
            if (accept) begin
               if (dec_mul) begin
                  state_d   = MUL_BUSY;
                  mul_start = 1'b1;
                  mul_s_d   = in_s;
               end else begin
                  valid_d = 1'b1;
                  res_d   = dec_res;
                  wb_d    = dec_wb;
                  if (dec_upd_nz) begin
                     sr_d[FLAG_Z] = (dec_res == '0);
                     sr_d[FLAG_N] = dec_res[WIDTH-1];
                  end
                  if (dec_upd_cv) begin
                     sr_d[FLAG_C] = sum[WIDTH];
                     sr_d[FLAG_V] = dec_v;
                  end
               end
            end
         end
         MUL_BUSY: begin
            if (mul_done) begin
               state_d = MUL_DONE;
            end
         end
         MUL_DONE: begin
            // The output register is empty here: acceptance required it free.
            state_d = MUL_IDLE;
            valid_d = 1'b1;
            res_d   = mul_product;
            wb_d    = 1'b1;
            if (mul_s_q) begin
               sr_d[FLAG_Z] = (mul_product == '0);
               sr_d[FLAG_N] = mul_product[WIDTH-1];
            end
         end
         default: state_d = MUL_IDLE;
      endcase
   end

   // State, output and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= MUL_IDLE;
         res_q      <= '0;
         wb_q       <= 1'b0;
         valid_q    <= 1'b0;
         sr_q       <= 4'b0000;
         mul_s_q    <= 1'b0;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         res_q      <= res_d;
         wb_q       <= wb_d;
         valid_q    <= valid_d;
         sr_q       <= sr_d;
         mul_s_q    <= mul_s_d;
         ready_en_q <= 1'b1;
      end
   end

   generate
      if (MUL_EN) begin : g_mul
         alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (mul_start),
            .op_a    (in_val1),
            .op_b    (in_val2),
            .done    (mul_done),
            .product (mul_product)
         );
      end else begin : g_no_mul
         assign mul_done    = 1'b0;
         assign mul_product = '0;
      end
   endgenerate

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed vectors, random ops
// against an arithmetic reference model, MUL timing, backpressure, reset.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 32;
   localparam longint SMAX = 64'sh7FFFFFFF;
   localparam longint SMIN = -64'sh80000000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    in_cmd = 4'd0;
   logic          in_s = 1'b0;
   logic [W-1:0]  in_val1 = '0;
   logic [W-1:0]  in_val2 = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_result;
   logic          out_wb;
   logic [3:0]    sr;

   int checks = 0;
   int failures = 0;
   logic [3:0] m_sr = 4'b0000;   // model status {Z,C,N,V}

   alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_cmd(in_cmd), .in_s(in_s), .in_val1(in_val1), .in_val2(in_val2),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_wb(out_wb), .sr(sr)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference model: plain integer arithmetic, updates m_sr.
   function automatic void model(input logic [3:0] cmd, input logic s,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic wb);
      longint unsigned ua, ub, t;
      longint sa, sb, st;
      int cc, bw;
      logic nz, cv, c_new, v_new;
      ua = a; ub = b;
      sa = longint'($signed(a)); sb = longint'($signed(b));
      r = '0; wb = 1'b0; nz = 1'b0; cv = 1'b0; c_new = 1'b0; v_new = 1'b0;
      case (cmd)
         OP_MOV: begin r = b;     wb = 1'b1; nz = s; end
         OP_MVN: begin r = ~b;    wb = 1'b1; nz = s; end
         OP_AND: begin r = a & b; wb = 1'b1; nz = s; end
         OP_ORR: begin r = a | b; wb = 1'b1; nz = s; end
         OP_EOR: begin r = a ^ b; wb = 1'b1; nz = s; end
         OP_TST: begin r = a & b; nz = 1'b1; end
         OP_ADD, OP_ADC: begin
            cc = (cmd == OP_ADC) ? int'(m_sr[2]) : 0;
            t = ua + ub + longint'(cc);
            r = t[31:0];
            c_new = (t > 64'hFFFFFFFF);
            st = sa + sb + longint'(cc);
            v_new = (st > SMAX) || (st < SMIN);
            wb = 1'b1; nz = s; cv = s;
         end
         OP_SUB, OP_SBC, OP_CMP: begin
            bw = (cmd == OP_SBC) ? int'(!m_sr[2]) : 0;
            t = ua - ub - longint'(bw);
            r = t[31:0];
            c_new = (ua >= ub + longint'(bw));
            st = sa - sb - longint'(bw);
            v_new = (st > SMAX) || (st < SMIN);
            wb = (cmd != OP_CMP);
            nz = (cmd == OP_CMP) ? 1'b1 : s;
            cv = nz;
         end
         OP_MUL: begin t = ua * ub; r = t[31:0]; wb = 1'b1; nz = s; end
         default: begin end
      endcase
      if (nz) begin m_sr[3] = (r == 32'd0); m_sr[1] = r[31]; end
      if (cv) begin m_sr[2] = c_new; m_sr[0] = v_new; end
   endfunction

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'h7FFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   // Issues one command (out_ready held 1) and waits for its result.
   // lat = clock edges after the accepting edge until out_valid is seen.
   task automatic run_op(input logic [3:0] cmd, input logic s,
                         input logic [31:0] a, input logic [31:0] b, output int lat);
      int n;
      @(negedge clk);
      in_valid = 1'b1; in_cmd = cmd; in_s = s; in_val1 = a; in_val2 = b;
      n = 0;
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
         in_valid = 1'b0; lat = -1;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      checks++; if (out_result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h want 0", out_result); end
      checks++; if (out_wb !== 1'b0) begin failures++; $display("FAIL reset_wb: got %0b want 0", out_wb); end
      checks++; if (sr !== 4'b0000) begin failures++; $display("FAIL reset_sr: got %b want 0000", sr); end
      rst_n = 1'b1;
      m_sr = 4'b0000;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %0b want 1", in_ready); end
      $display("reset: checked");
   endtask

   typedef struct {
      logic [3:0] cmd; logic s; logic [31:0] a; logic [31:0] b;
      logic [31:0] res; logic chk_res; logic wb; logic [3:0] sr; int lat;
   } vec_t;

   task automatic test_directed();
      vec_t v[8];
      logic [31:0] mr; logic mwb; int lat;
      v[0] = '{OP_ADD, 1'b1, 32'h7FFFFFFF, 32'h1,   32'h80000000, 1'b1, 1'b1, 4'b0011, 0};
      v[1] = '{OP_ADD, 1'b1, 32'hFFFFFFFF, 32'h1,   32'h0,        1'b1, 1'b1, 4'b1100, 0};
      v[2] = '{OP_ADC, 1'b0, 32'h0,        32'h0,   32'h1,        1'b1, 1'b1, 4'b1100, 0};
      v[3] = '{OP_CMP, 1'b0, 32'h5,        32'h5,   32'h0,        1'b0, 1'b0, 4'b1100, 0};
      v[4] = '{OP_SUB, 1'b0, 32'h3,        32'h5,   32'hFFFFFFFE, 1'b1, 1'b1, 4'b1100, 0};
      v[5] = '{OP_MOV, 1'b1, 32'h0,        32'h80000000, 32'h80000000, 1'b1, 1'b1, 4'b0110, 0};
      v[6] = '{OP_MUL, 1'b1, 32'h10000,    32'h10000, 32'h0,      1'b1, 1'b1, 4'b1100, 33};
      v[7] = '{4'b1011, 1'b1, 32'h1234,    32'h5678, 32'h0,       1'b1, 1'b0, 4'b1100, 0};
      for (int i = 0; i < 8; i++) begin
         model(v[i].cmd, v[i].s, v[i].a, v[i].b, mr, mwb);
         run_op(v[i].cmd, v[i].s, v[i].a, v[i].b, lat);
         if (v[i].chk_res) begin
            checks++; if (out_result !== v[i].res) begin failures++; $display("FAIL dir%0d_result: got %h want %h", i, out_result, v[i].res); end
         end
         checks++; if (out_wb !== v[i].wb) begin failures++; $display("FAIL dir%0d_wb: got %0b want %0b", i, out_wb, v[i].wb); end
         checks++; if (sr !== v[i].sr) begin failures++; $display("FAIL dir%0d_sr: got %b want %b", i, sr, v[i].sr); end
         checks++; if (lat !== v[i].lat) begin failures++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, v[i].lat); end
         $display("directed %0d: cmd=%b a=%h b=%h -> result=%h wb=%0b sr=%b lat=%0d", i, v[i].cmd, v[i].a, v[i].b, out_result, out_wb, sr, lat);
      end
   endtask

   task automatic test_random_ops();
      logic [3:0] cmd; logic s; logic [31:0] a, b, mr; logic mwb; int lat;
      for (int i = 0; i < 60; i++) begin
         cmd = 4'($urandom_range(0, 15)); s = 1'($urandom_range(0, 1));
         a = pick_val(); b = pick_val();
         model(cmd, s, a, b, mr, mwb);
         run_op(cmd, s, a, b, lat);
         if (cmd != OP_CMP && cmd != OP_TST) begin
            checks++; if (out_result !== mr) begin failures++; $display("FAIL rand%0d_result: cmd=%b got %h want %h", i, cmd, out_result, mr); end
         end
         checks++; if (out_wb !== mwb) begin failures++; $display("FAIL rand%0d_wb: got %0b want %0b", i, out_wb, mwb); end
         checks++; if (sr !== m_sr) begin failures++; $display("FAIL rand%0d_sr: cmd=%b got %b want %b", i, cmd, sr, m_sr); end
         checks++; if (lat !== ((cmd == OP_MUL) ? 33 : 0)) begin failures++; $display("FAIL rand%0d_latency: got %0d", i, lat); end
         $display("random %0d: cmd=%b s=%0b a=%h b=%h -> result=%h sr=%b", i, cmd, s, a, b, out_result, sr);
      end
   endtask

   task automatic test_mul();
      logic s; logic [31:0] a, b, mr; logic mwb; int k, low;
      for (int i = 0; i < 4; i++) begin
         s = 1'($urandom_range(0, 1)); a = $urandom; b = (i == 0) ? 32'hFFFFFFFF : $urandom;
         model(OP_MUL, s, a, b, mr, mwb);
         @(negedge clk);
         in_valid = 1'b1; in_cmd = OP_MUL; in_s = s; in_val1 = a; in_val2 = b;
         k = 0;
         while (!in_ready && k < 100) begin @(negedge clk); k++; end
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         k = 0; low = 0;
         while (!out_valid && k < 100) begin
            if (!in_ready) low++;
            @(negedge clk); k++;
         end
         checks++; if (k !== 33) begin failures++; $display("FAIL mul%0d_latency: got %0d want 33", i, k); end
         checks++; if (low !== 33) begin failures++; $display("FAIL mul%0d_ready_low: got %0d want 33", i, low); end
         checks++; if (out_result !== mr) begin failures++; $display("FAIL mul%0d_result: got %h want %h", i, out_result, mr); end
         checks++; if (sr !== m_sr) begin failures++; $display("FAIL mul%0d_sr: got %b want %b", i, sr, m_sr); end
         $display("mul %0d: %h*%h -> %h sr=%b cycles=%0d", i, a, b, out_result, sr, k);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] cmd; logic s; logic [31:0] a, b;
      logic [31:0] exp_r[$]; logic exp_wb[$]; logic [3:0] exp_sr[$]; logic exp_chk[$];
      logic [31:0] mr; logic mwb;
      @(negedge clk);
      for (int i = 0; i <= 30; i++) begin
         if (i > 0) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b%0d_valid: got %0b want 1", i-1, out_valid); end
            if (exp_chk[i-1]) begin
               checks++; if (out_result !== exp_r[i-1]) begin failures++; $display("FAIL b2b%0d_result: got %h want %h", i-1, out_result, exp_r[i-1]); end
            end
            checks++; if (out_wb !== exp_wb[i-1]) begin failures++; $display("FAIL b2b%0d_wb: got %0b want %0b", i-1, out_wb, exp_wb[i-1]); end
            checks++; if (sr !== exp_sr[i-1]) begin failures++; $display("FAIL b2b%0d_sr: got %b want %b", i-1, sr, exp_sr[i-1]); end
            $display("b2b %0d: result=%h wb=%0b sr=%b", i-1, out_result, out_wb, sr);
         end
         if (i == 30) break;
         cmd = 4'($urandom_range(0, 15));
         if (cmd == OP_MUL) cmd = OP_ADC;
         s = 1'($urandom_range(0, 1)); a = pick_val(); b = pick_val();
         model(cmd, s, a, b, mr, mwb);
         exp_r.push_back(mr); exp_wb.push_back(mwb); exp_sr.push_back(m_sr);
         exp_chk.push_back(cmd != OP_CMP && cmd != OP_TST);
         in_valid = 1'b1; in_cmd = cmd; in_s = s; in_val1 = a; in_val2 = b;
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b%0d_ready: got %0b want 1", i, in_ready); end
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [31:0] a, b, r_add, r_mov; logic mwb;
      a = $urandom; b = $urandom;
      @(negedge clk);
      out_ready = 1'b0;
      model(OP_ADD, 1'b1, a, b, r_add, mwb);
      in_valid = 1'b1; in_cmd = OP_ADD; in_s = 1'b1; in_val1 = a; in_val2 = b;
      @(negedge clk);
      in_cmd = OP_MOV; in_s = 1'b0; in_val2 = 32'h5A5A0F0F;
      model(OP_MOV, 1'b0, 32'h0, 32'h5A5A0F0F, r_mov, mwb);
      for (int k = 1; k <= 3; k++) begin
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp%0d_valid: got %0b want 1", k, out_valid); end
         checks++; if (out_result !== r_add) begin failures++; $display("FAIL bp%0d_result: got %h want %h", k, out_result, r_add); end
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp%0d_in_ready: got %0b want 0", k, in_ready); end
         $display("backpressure cycle %0d: result=%h in_ready=%0b", k, out_result, in_ready);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_result !== r_mov) begin failures++; $display("FAIL bp_next_result: valid=%0b got %h want %h", out_valid, out_result, r_mov); end
      checks++; if (sr !== m_sr) begin failures++; $display("FAIL bp_sr: got %b want %b", sr, m_sr); end
      $display("backpressure release: result=%h sr=%b", out_result, sr);
   endtask

   task automatic test_reset_mid_mul();
      int lat;
      @(negedge clk);
      in_valid = 1'b1; in_cmd = OP_MUL; in_s = 1'b1; in_val1 = $urandom; in_val2 = $urandom;
      while (!in_ready) @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmul_valid: got %0b want 0", out_valid); end
      checks++; if (sr !== 4'b0000) begin failures++; $display("FAIL rstmul_sr: got %b want 0000", sr); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rstmul_ready: got %0b want 0", in_ready); end
      m_sr = 4'b0000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_op(OP_MOV, 1'b0, 32'h0, 32'hA5, lat);
      checks++; if (out_result !== 32'hA5) begin failures++; $display("FAIL rstmul_mov_result: got %h want 000000a5", out_result); end
      checks++; if (lat !== 0) begin failures++; $display("FAIL rstmul_mov_latency: got %0d want 0", lat); end
      checks++; if (sr !== 4'b0000) begin failures++; $display("FAIL rstmul_mov_sr: got %b want 0000", sr); end
      $display("reset mid-MUL: then MOV result=%h lat=%0d", out_result, lat);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random_ops();
      test_mul();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_mul();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
